// File: rtl/addr_map_cfg.sv
// Runtime-programmable address decoder: a register-port-written rule table
// and a one-deep registered lookup pipeline with miss/multi-hit reporting.
module addr_map_cfg #(
    parameter int unsigned NrRules      = 9,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned CntWidth     = 32,
    parameter int unsigned IdxWidth     = (NrRules > 1) ? $clog2(NrRules) : 1,
    parameter int unsigned CfgAddrWidth = $clog2(3 * NrRules + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [CfgAddrWidth-1:0] cfg_addr_i,
    input  logic [AddrWidth-1:0]    cfg_wdata_i,
    output logic                    cfg_rvalid_o,
    output logic [AddrWidth-1:0]    cfg_rdata_o,
    output logic                    cfg_err_o,
    input  logic                    lk_valid_i,
    output logic                    lk_ready_o,
    input  logic [AddrWidth-1:0]    lk_addr_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic                    res_hit_o,
    output logic                    res_multi_o,
    output logic [IdxWidth-1:0]     res_idx_o
);

    localparam int unsigned CntIdx = 3 * NrRules;

    logic [AddrWidth-1:0] r_base [NrRules];
    logic [AddrWidth-1:0] r_len  [NrRules];
    logic [NrRules-1:0]   r_en;
    logic [NrRules-1:0]   r_lock;
    logic [CntWidth-1:0]  r_miss_cnt;

    logic [NrRules-1:0]   w_sel_base;
    logic [NrRules-1:0]   w_sel_len;
    logic [NrRules-1:0]   w_sel_ctrl;
    logic                 w_sel_locked;
    logic [AddrWidth-1:0] w_rd_val;
    logic                 w_is_cnt;
    logic                 w_bad;
    logic                 w_wr;
    logic                 w_cfg_err;
    logic                 w_cnt_clr;

    logic [NrRules-1:0]   w_match;
    logic                 w_hit;
    logic                 w_multi;
    logic [IdxWidth-1:0]  w_idx;
    logic                 w_lk_fire;

    // Decode the register word index into per-rule field selects and read data
    always_comb begin
        w_sel_base   = '0;
        w_sel_len    = '0;
        w_sel_ctrl   = '0;
        w_sel_locked = 1'b0;
        w_rd_val     = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (cfg_addr_i == CfgAddrWidth'(3 * i)) begin
                w_sel_base[i] = 1'b1;
                w_sel_locked  = r_lock[i];
                w_rd_val      = r_base[i];
            end
            if (cfg_addr_i == CfgAddrWidth'(3 * i + 1)) begin
                w_sel_len[i]  = 1'b1;
                w_sel_locked  = r_lock[i];
                w_rd_val      = r_len[i];
            end
            if (cfg_addr_i == CfgAddrWidth'(3 * i + 2)) begin
                w_sel_ctrl[i] = 1'b1;
                w_sel_locked  = r_lock[i];
                w_rd_val      = AddrWidth'({r_lock[i], r_en[i]});
            end
        end
        w_is_cnt = (cfg_addr_i == CfgAddrWidth'(CntIdx));
        w_bad    = (cfg_addr_i >  CfgAddrWidth'(CntIdx));
        if (w_is_cnt) begin
            w_rd_val = AddrWidth'(r_miss_cnt);
        end
    end

    assign w_wr      = cfg_req_i && cfg_we_i && !w_bad && !w_sel_locked;
    assign w_cfg_err = cfg_req_i && (w_bad || (cfg_we_i && w_sel_locked));
    assign w_cnt_clr = w_wr && w_is_cnt;

    // Rule table; a locked rule blocks all writes so lock stays set until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                r_base[i] <= '0;
                r_len[i]  <= '0;
            end
            r_en   <= '0;
            r_lock <= '0;
        end else begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                if (w_wr && w_sel_base[i]) begin
                    r_base[i] <= cfg_wdata_i;
                end
                if (w_wr && w_sel_len[i]) begin
                    r_len[i] <= cfg_wdata_i;
                end
                if (w_wr && w_sel_ctrl[i]) begin
                    r_en[i]   <= cfg_wdata_i[0];
                    r_lock[i] <= cfg_wdata_i[1];
                end
            end
        end
    end

    // Register-port response, one cycle after the request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= w_cfg_err;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !w_bad) ? w_rd_val : '0;
        end
    end

    // Per-rule range match; subtraction only after base<=addr so it cannot wrap
    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            w_match[i] = r_en[i] && (r_len[i] != '0) && (lk_addr_i >= r_base[i])
                         && ((lk_addr_i - r_base[i]) < r_len[i]);
        end
    end

    // Lowest matching index wins; a second match flags multi-hit
    always_comb begin
        w_hit   = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (w_match[i]) begin
                if (w_hit) begin
                    w_multi = 1'b1;
                end else begin
                    w_idx = IdxWidth'(i);
                end
                w_hit = 1'b1;
            end
        end
    end

    assign lk_ready_o = !res_valid_o || res_ready_i;
    assign w_lk_fire  = lk_valid_i && lk_ready_o;

    // Result register; holds while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_o <= 1'b0;
            res_hit_o   <= 1'b0;
            res_multi_o <= 1'b0;
            res_idx_o   <= '0;
        end else if (w_lk_fire) begin
            res_valid_o <= 1'b1;
            res_hit_o   <= w_hit;
            res_multi_o <= w_multi;
            res_idx_o   <= w_idx;
        end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

    // Saturating miss counter; a clear on the same edge as a miss wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_miss_cnt <= '0;
        end else if (w_lk_fire && !w_hit && (r_miss_cnt != {CntWidth{1'b1}})) begin
            r_miss_cnt <= r_miss_cnt + CntWidth'(1);
        end
    end

endmodule

// File: tb/tb_addr_map_cfg.sv
// Directed bench for addr_map_cfg: table of register/lookup vectors plus
// hand sequences for backpressure, same-edge ordering, counter saturation
// and mid-transaction reset. A second instance uses a 2-bit miss counter.
module tb_addr_map_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_req;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [63:0] cfg_wdata;
    logic        cfg_rvalid, cfg_err;
    logic [63:0] cfg_rdata;
    logic        lk_valid, lk_ready;
    logic [63:0] lk_addr;
    logic        res_valid, res_ready, res_hit, res_multi;
    logic [3:0]  res_idx;

    logic        cfg_rvalid2, cfg_err2, lk_ready2, res_valid2, res_hit2, res_multi2;
    logic [63:0] cfg_rdata2;
    logic [3:0]  res_idx2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    addr_map_cfg dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_hit_o(res_hit),
        .res_multi_o(res_multi), .res_idx_o(res_idx)
    );

    addr_map_cfg #(.CntWidth(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_rvalid_o(cfg_rvalid2), .cfg_rdata_o(cfg_rdata2), .cfg_err_o(cfg_err2),
        .lk_valid_i(lk_valid), .lk_ready_o(lk_ready2), .lk_addr_i(lk_addr),
        .res_valid_o(res_valid2), .res_ready_i(res_ready), .res_hit_o(res_hit2),
        .res_multi_o(res_multi2), .res_idx_o(res_idx2)
    );

    typedef struct {
        int          kind;      // 0 write, 1 read, 2 lookup
        logic [4:0]  addr;
        logic [63:0] data;      // write data or lookup address
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_hit;
        logic        exp_multi;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic void vw(input logic [4:0] a, input logic [63:0] d, input logic e);
        vec_t v;
        v.kind = 0; v.addr = a; v.data = d; v.exp_rdata = 64'h0; v.exp_err = e;
        v.exp_hit = 1'b0; v.exp_multi = 1'b0; v.exp_idx = 4'd0;
        vecs.push_back(v);
    endfunction

    function automatic void vr(input logic [4:0] a, input logic [63:0] r, input logic e);
        vec_t v;
        v.kind = 1; v.addr = a; v.data = 64'h0; v.exp_rdata = r; v.exp_err = e;
        v.exp_hit = 1'b0; v.exp_multi = 1'b0; v.exp_idx = 4'd0;
        vecs.push_back(v);
    endfunction

    function automatic void vl(input logic [63:0] a, input logic h, input logic m, input logic [3:0] i);
        vec_t v;
        v.kind = 2; v.addr = 5'd0; v.data = a; v.exp_rdata = 64'h0; v.exp_err = 1'b0;
        v.exp_hit = h; v.exp_multi = m; v.exp_idx = i;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_op(input logic we, input logic [4:0] a, input logic [63:0] d);
        cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_wdata = 64'h0;
    endtask

    task automatic lookup(input logic [63:0] a);
        lk_valid = 1'b1; lk_addr = a; res_ready = 1'b1;
        @(posedge clk); #1;
        lk_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_wdata = 64'h0;
        lk_valid = 1'b0; lk_addr = 64'h0; res_ready = 1'b1;

        // Basic decode
        vw(5'd0, 64'h8000_0000, 1'b0);
        vw(5'd1, 64'h4000_0000, 1'b0);
        vw(5'd2, 64'h1, 1'b0);
        vw(5'd12, 64'h1000_0000, 1'b0);
        vw(5'd13, 64'h1000, 1'b0);
        vw(5'd14, 64'h1, 1'b0);
        vl(64'h8000_0010, 1'b1, 1'b0, 4'd0);
        vl(64'h1000_0FFF, 1'b1, 1'b0, 4'd4);
        vl(64'h1000_1000, 1'b0, 1'b0, 4'd0);
        vr(5'd27, 64'd1, 1'b0);
        vl(64'hBFFF_FFFF, 1'b1, 1'b0, 4'd0);
        vl(64'hC000_0000, 1'b0, 1'b0, 4'd0);
        vr(5'd1, 64'h4000_0000, 1'b0);
        vr(5'd2, 64'h1, 1'b0);
        // Overlap and priority
        vw(5'd3, 64'h0, 1'b0);
        vw(5'd4, 64'h2000, 1'b0);
        vw(5'd5, 64'h1, 1'b0);
        vw(5'd6, 64'h1000, 1'b0);
        vw(5'd7, 64'h1000, 1'b0);
        vw(5'd8, 64'h1, 1'b0);
        vl(64'h1800, 1'b1, 1'b1, 4'd1);
        vl(64'h0FFF, 1'b1, 1'b0, 4'd1);
        vw(5'd5, 64'h0, 1'b0);
        vl(64'h1800, 1'b1, 1'b0, 4'd2);
        vl(64'h2000, 1'b0, 1'b0, 4'd0);
        // Zero length never matches
        vw(5'd18, 64'h5000, 1'b0);
        vw(5'd19, 64'h0, 1'b0);
        vw(5'd20, 64'h1, 1'b0);
        vl(64'h5000, 1'b0, 1'b0, 4'd0);
        vr(5'd20, 64'h1, 1'b0);
        // Region ending at 2^64
        vw(5'd21, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
        vw(5'd22, 64'h1000, 1'b0);
        vw(5'd23, 64'h1, 1'b0);
        vl(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd7);
        vl(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 1'b0, 4'd0);
        vr(5'd27, 64'd5, 1'b0);
        // Lock
        vw(5'd11, 64'h3, 1'b0);
        vr(5'd11, 64'h3, 1'b0);
        vw(5'd9, 64'h5, 1'b1);
        vr(5'd9, 64'h0, 1'b0);
        vw(5'd11, 64'h0, 1'b1);
        vr(5'd11, 64'h3, 1'b0);
        vw(5'd10, 64'h77, 1'b1);
        // Ctrl unused bits read 0; bad indices
        vw(5'd17, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        vr(5'd17, 64'h0, 1'b0);
        vr(5'd28, 64'h0, 1'b1);
        vw(5'd31, 64'h1, 1'b1);
        vr(5'd26, 64'h0, 1'b0);
        // Counter clear
        vw(5'd27, 64'h123, 1'b0);
        vr(5'd27, 64'h0, 1'b0);

        #12;
        chk("rst res_valid", 64'(res_valid), 64'h0);
        chk("rst cfg_rvalid", 64'(cfg_rvalid), 64'h0);
        chk("rst cfg_rdata", cfg_rdata, 64'h0);
        chk("rst lk_ready", 64'(lk_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].kind == 2) begin
                lookup(vecs[i].data);
                chk($sformatf("v%0d res_valid", i), 64'(res_valid), 64'h1);
                chk($sformatf("v%0d hit", i), 64'(res_hit), 64'(vecs[i].exp_hit));
                chk($sformatf("v%0d multi", i), 64'(res_multi), 64'(vecs[i].exp_multi));
                chk($sformatf("v%0d idx", i), 64'(res_idx), 64'(vecs[i].exp_idx));
            end else begin
                cfg_op(vecs[i].kind == 0, vecs[i].addr, vecs[i].data);
                chk($sformatf("v%0d rvalid", i), 64'(cfg_rvalid), 64'h1);
                chk($sformatf("v%0d err", i), 64'(cfg_err), 64'(vecs[i].exp_err));
                chk($sformatf("v%0d rdata", i), cfg_rdata, vecs[i].exp_rdata);
            end
        end

        // Backpressure: rule8 = [0x9000, 0x9100)
        cfg_op(1'b1, 5'd24, 64'h9000);
        cfg_op(1'b1, 5'd25, 64'h100);
        cfg_op(1'b1, 5'd26, 64'h1);
        res_ready = 1'b0; lk_valid = 1'b1; lk_addr = 64'h9010;
        @(posedge clk); #1;
        chk("bp first valid", 64'(res_valid), 64'h1);
        chk("bp first idx", 64'(res_idx), 64'd8);
        chk("bp ready low", 64'(lk_ready), 64'h0);
        lk_addr = 64'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d valid", c), 64'(res_valid), 64'h1);
            chk($sformatf("bp hold%0d hit", c), 64'(res_hit), 64'h1);
            chk($sformatf("bp hold%0d idx", c), 64'(res_idx), 64'd8);
            chk($sformatf("bp hold%0d ready", c), 64'(lk_ready), 64'h0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp release ready", 64'(lk_ready), 64'h1);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        chk("bp next valid", 64'(res_valid), 64'h1);
        chk("bp next hit", 64'(res_hit), 64'h0);
        @(posedge clk); #1;
        chk("bp drained", 64'(res_valid), 64'h0);

        // Same-edge enable and lookup: rule5 = [0x7000_0000, +0x100)
        cfg_op(1'b1, 5'd15, 64'h7000_0000);
        cfg_op(1'b1, 5'd16, 64'h100);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd17; cfg_wdata = 64'h1;
        lk_valid = 1'b1; lk_addr = 64'h7000_0010; res_ready = 1'b1;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0; lk_valid = 1'b0;
        chk("same-edge hit old", 64'(res_hit), 64'h0);
        chk("same-edge cfg err", 64'(cfg_err), 64'h0);
        lookup(64'h7000_0010);
        chk("after-edge hit", 64'(res_hit), 64'h1);
        chk("after-edge idx", 64'(res_idx), 64'd5);

        // Clear and miss on the same edge: clear wins
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd27; cfg_wdata = 64'h0;
        lk_valid = 1'b1; lk_addr = 64'h1234_5678;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0; lk_valid = 1'b0;
        cfg_op(1'b0, 5'd27, 64'h0);
        chk("clear-wins cnt", cfg_rdata, 64'd0);

        // Saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) lookup(64'h1234_5678);
        cfg_op(1'b0, 5'd27, 64'h0);
        chk("cnt32 five misses", cfg_rdata, 64'd5);
        chk("cnt2 saturated", cfg_rdata2, 64'd3);
        cfg_op(1'b1, 5'd27, 64'h1);
        cfg_op(1'b0, 5'd27, 64'h0);
        chk("cnt2 cleared", cfg_rdata2, 64'd0);
        chk("cnt32 cleared", cfg_rdata, 64'd0);

        // Reset with a stalled result and a pending read response
        res_ready = 1'b0; lk_valid = 1'b1; lk_addr = 64'h8000_0000;
        @(posedge clk); #1;
        lk_valid = 1'b0;
        chk("pre-rst valid", 64'(res_valid), 64'h1);
        chk("pre-rst hit", 64'(res_hit), 64'h1);
        cfg_op(1'b0, 5'd0, 64'h0);
        chk("pre-rst rvalid", 64'(cfg_rvalid), 64'h1);
        chk("pre-rst rdata", cfg_rdata, 64'h8000_0000);
        rst_n = 1'b0;
        #1;
        chk("rst res_valid now", 64'(res_valid), 64'h0);
        chk("rst res_hit now", 64'(res_hit), 64'h0);
        chk("rst cfg_rvalid now", 64'(cfg_rvalid), 64'h0);
        chk("rst cfg_rdata now", cfg_rdata, 64'h0);
        chk("rst dut2 res_valid", 64'(res_valid2), 64'h0);
        chk("rst dut2 outs", 64'({cfg_rvalid2, cfg_err2, res_hit2, res_multi2, res_idx2}), 64'h0);
        chk("rst dut2 lk_ready", 64'(lk_ready2), 64'h1);
        #2;
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int w = 0; w <= 27; w++) begin
            cfg_op(1'b0, 5'(w), 64'h0);
            chk($sformatf("post-rst word%0d", w), cfg_rdata, 64'h0);
            chk($sformatf("post-rst err%0d", w), 64'(cfg_err), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/addr_map_cfg.md
Name: addr_map_cfg

Overview:
- Runtime-programmable SoC address decoder; successor to the fixed compile-time slave map.
- Holds NrRules base/length/enable/lock entries, written through a simple register port by boot firmware or the debug module.
- Resolves a stream of lookup addresses to a slave index with a one-cycle registered pipeline.
- Reports miss and multi-hit, and counts misses; sits beside the AXI crossbar address decode.

Parameters:
- NrRules, 9, number of address rules (slave ports); range 1..32
- AddrWidth, 64, lookup, base and length width
- CntWidth, 32, miss counter width (saturating)
- IdxWidth, $clog2(NrRules) (min 1), derived width of a rule index

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_req_i  in  1  register access request, single cycle
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  $clog2(3*NrRules+1)  word index
- cfg_wdata_i  in  AddrWidth  write data
- cfg_rvalid_o  out  1  response valid, one cycle after cfg_req_i
- cfg_rdata_o  out  AddrWidth  read data
- cfg_err_o  out  1  error flag, qualified by cfg_rvalid_o
- lk_valid_i  in  1  lookup request valid
- lk_ready_o  out  1  lookup request ready
- lk_addr_i  in  AddrWidth  lookup address
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- res_hit_o  out  1  at least one enabled rule matched
- res_multi_o  out  1  more than one rule matched
- res_idx_o  out  IdxWidth  lowest matching rule index (0 on miss)

Behaviour:
- Reset (async, active-low):
  - All rules: base 0, length 0, enable 0, lock 0. Miss counter 0.
  - All outputs 0: cfg_rvalid_o, cfg_rdata_o, cfg_err_o, res_*.
- Register map (word index):
  - 3i+0 = base of rule i; 3i+1 = length of rule i.
  - 3i+2 = ctrl of rule i: bit0 enable, bit1 lock; other bits read 0.
  - 3*NrRules = miss counter: read returns the zero-extended count; any write clears it.
- Register access:
  - Read: cfg_rdata_o is registered and valid with cfg_rvalid_o one cycle after the request.
  - Write: takes effect at the clock edge of the request; cfg_rdata_o = 0 on write responses.
- Register errors (cfg_err_o = 1 in the response cycle):
  - Index greater than 3*NrRules: read returns 0; write is dropped.
  - Write to a locked rule (any of its 3 words): write is dropped.
  - Reads of a locked rule are allowed with no error.
- Lock: once set, it is cleared only by reset. A write that sets lock also applies the enable bit of the same write.
- Match rule:
  - Rule i matches when enable=1, length!=0, addr>=base and (addr-base)<length.
  - All arithmetic is unsigned AddrWidth with no overflow; a region ending exactly at 2^AddrWidth is legal.
  - length=0 never matches.
- Lookup pipeline (one output register):
  - lk_ready_o = !res_valid_o || res_ready_i.
  - On lk_valid_i && lk_ready_o, the result is computed from the table as it is before that edge's config write, then registered.
  - res_valid_o rises the next cycle.
  - Result holds stable while res_valid_o && !res_ready_i.
  - Back-to-back accepts give one result per cycle.
- Priority: the lowest matching index wins; res_multi_o = 1 when the popcount of matches is >= 2.
- Miss counter:
  - Increments by 1 on each accepted lookup with no hit; saturates at 2^CntWidth-1.
  - A clear on the same edge as an increment leaves the counter at 0 (clear wins).
- Simultaneous config write and lookup accept: the lookup sees the old value; the next accept sees the new value.
- Reset asserted mid-transaction: the in-flight result and any pending register response are discarded immediately (valids go 0).

Test Plan:
- Program rule0 base 0x8000_0000 / len 0x4000_0000 / en, rule4 base 0x1000_0000 / len 0x1000 / en; lookup 0x8000_0010 -> hit=1, idx=0, multi=0; lookup 0x1000_0FFF -> idx=4; lookup 0x1000_1000 -> hit=0, miss counter reads 1.
- Overlap: rule1 base 0x0, len 0x2000; rule2 base 0x1000, len 0x1000; both enabled; lookup 0x1800 -> idx=1, multi=1. Disable rule1 -> idx=2, multi=0.
- Lock: write rule3 ctrl=0x3, then write rule3 base 0x5 -> cfg_err_o=1, base reads the old value. Read index 3*NrRules+1 -> err=1, rdata=0.
- Backpressure: hold res_ready_i=0 for 3 cycles with lk_valid_i=1 -> lk_ready_o=0, result stable. Release -> next address accepted the same cycle, result the following cycle.
- Same-edge write and lookup: in one cycle, enable rule5 and accept a lookup in its range -> hit=0. Next lookup -> hit=1, idx=5.
- Boundaries:
  - Rule base 0xFFFF_FFFF_FFFF_F000, len 0x1000; lookup 0xFFFF_FFFF_FFFF_FFFF -> hit=1.
  - CntWidth=2 build: 5 misses -> counter reads 3; write clears -> 0.
  - Assert rst_ni while res_valid_o=1 -> res_valid_o=0 immediately and all rules read 0.
